// File: rtl/count_uart_tx.sv
// Snapshots an 8-bit count and serialises it as a UART 8N1 frame on tx.
// A one-deep pending buffer holds a snapshot taken mid-frame; overwriting it sets a sticky overrun flag.
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] count_in,
    input  logic       send_on_change,
    input  logic       send_req,
    input  logic       overrun_clr,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [7:0]    prev_q;
    logic [7:0]    shift_q;
    logic [7:0]    pend_q;
    logic          pend_full;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;

    logic trigger;
    logic bit_end;
    logic stop_end;

    assign trigger  = en & (send_req | (send_on_change & (count_in != prev_q)));
    assign bit_end  = (baud_q == BAUD_LAST);
    assign stop_end = (state == STOP) && bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prev_q    <= 8'h00;
            shift_q   <= 8'h00;
            pend_q    <= 8'h00;
            pend_full <= 1'b0;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            prev_q <= count_in;
            if (overrun_clr) overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state   <= START;
                        shift_q <= count_in;
                        baud_q  <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        baud_q <= '0;
                        bit_q  <= 3'd0;
                        tx     <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (pend_full) begin
                            // A coincident trigger refills the slot just vacated, so no overrun.
                            state     <= START;
                            shift_q   <= pend_q;
                            tx        <= 1'b0;
                            pend_full <= trigger;
                        end else if (trigger) begin
                            state   <= START;
                            shift_q <= count_in;
                            tx      <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase

            if (trigger && state != IDLE) begin
                if (stop_end) begin
                    if (pend_full) pend_q <= count_in;
                end else begin
                    if (pend_full) overrun <= 1'b1;
                    pend_q    <= count_in;
                    pend_full <= 1'b1;
                end
            end
        end
    end

endmodule
